// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the CPU control blocks.
// Holds the sequencer state encoding and fetch geometry.
package cpu_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int INSTR_BYTES    = 4;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        IDLE   = 3'd1,
        RUN    = 3'd2,
        STEP   = 3'd3,
        DRAIN  = 3'd4,
        HALTED = 3'd5
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and its surroundings.
// master = sequencer, slave = PC register / decode / debug side.
interface pc_sequencer_if
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  cmd_run;
    logic                  cmd_step;
    logic                  cmd_stop;
    logic [ADDR_WIDTH-1:0] pc_current;
    logic                  stall;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  halt_instr;
    logic                  pc_enable;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  flush;
    logic [2:0]            state_out;
    logic                  halted;
    logic [31:0]           fetch_count;

    modport master (
        input  cmd_run, cmd_step, cmd_stop,
        input  pc_current, stall,
        input  branch_taken, branch_target,
        input  jump, jump_target, halt_instr,
        output pc_enable, pc_next, flush,
        output state_out, halted, fetch_count
    );

    modport slave (
        output cmd_run, cmd_step, cmd_stop,
        output pc_current, stall,
        output branch_taken, branch_target,
        output jump, jump_target, halt_instr,
        input  pc_enable, pc_next, flush,
        input  state_out, halted, fetch_count
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next fetch address select: boot vector, branch, jump or PC+4.
// Purely combinational; +4 wraps modulo 2^ADDR_WIDTH.
module pc_next_mux
    import cpu_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  boot,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] pc_next
);

    logic [ADDR_WIDTH-1:0] pc_seq;

    assign pc_seq = pc_current + ADDR_WIDTH'(INSTR_BYTES);

    // Boot vector wins, then branch over jump, else sequential.
    always_comb begin
        pc_next = pc_seq;
        priority case (1'b1)
            boot:         pc_next = RESET_ADDR;
            branch_taken: pc_next = branch_target;
            jump:         pc_next = jump_target;
            default:      pc_next = pc_seq;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: run/step/stop/halt control FSM, drain timer
// and saturating fetch counter driving the PC register.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0,
    parameter int                    DRAIN_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_d;
    logic [3:0]  drain_cnt;
    logic [3:0]  drain_d;
    logic [31:0] fetch_cnt;
    logic [31:0] fetch_d;
    logic        pc_en;
    logic        in_boot;

    assign in_boot = (state == BOOT);

    pc_next_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_mux (
        .boot          (in_boot),
        .pc_current    (bus.pc_current),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .pc_next       (bus.pc_next)
    );

    // State, drain timer and fetch counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            drain_cnt <= '0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_d;
            drain_cnt <= drain_d;
            fetch_cnt <= fetch_d;
        end
    end

    // Next state, PC write enable and drain timer update.
    always_comb begin
        state_d = state;
        drain_d = drain_cnt;
        pc_en   = 1'b0;
        unique case (state)
            BOOT: begin
                pc_en   = !reset;
                state_d = IDLE;
            end
            IDLE: begin
                if (bus.cmd_stop)      state_d = IDLE;
                else if (bus.cmd_run)  state_d = RUN;
                else if (bus.cmd_step) state_d = STEP;
            end
            RUN: begin
                if (bus.halt_instr) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    pc_en = !bus.stall;
                    if (bus.cmd_stop) state_d = IDLE;
                end
            end
            STEP: begin
                if (bus.halt_instr) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    pc_en = !bus.stall;
                    if (!bus.stall) state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) state_d = HALTED;
                else                 drain_d = drain_cnt - 4'd1;
            end
            HALTED: state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    // Fetch counter advances on each PC write and sticks at max.
    always_comb begin
        fetch_d = fetch_cnt;
        if (pc_en && (fetch_cnt != '1)) fetch_d = fetch_cnt + 32'd1;
    end

    assign bus.pc_enable   = pc_en;
    assign bus.flush       = pc_en & (bus.branch_taken | bus.jump);
    assign bus.state_out   = state;
    assign bus.halted      = (state == HALTED);
    assign bus.fetch_count = fetch_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: rule-level reference model compared
// every cycle, plus directed literal expectations.
module tb_pc_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int DC = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    pc_sequencer #(
        .ADDR_WIDTH   (AW),
        .RESET_ADDR   (32'h0),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in PC register fed by the sequencer outputs.
    logic [31:0] pc_reg = '0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = '0;

    // PC register: optional backdoor load, else sequencer write.
    always @(posedge clk) begin
        if (pc_load)            pc_reg <= pc_load_val;
        else if (bus.pc_enable) pc_reg <= bus.pc_next;
    end

    assign bus.pc_current = pc_reg;

    // Reference model state.
    int          m_state = 0;
    int          m_drain = 0;
    logic [63:0] m_cnt   = '0;
    logic        preload = 1'b0;
    logic        chk_en  = 1'b0;
    logic        cnt_chk = 1'b1;

    function automatic bit exp_en();
        case (m_state)
            0:       return !reset;
            2, 3:    return !bus.stall && !bus.halt_instr;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] exp_next();
        if (m_state == 0)     return 64'h0;
        if (bus.branch_taken) return {32'h0, bus.branch_target};
        if (bus.jump)         return {32'h0, bus.jump_target};
        return ({32'h0, bus.pc_current} + 64'd4) % 64'h1_0000_0000;
    endfunction

    // Model state advance from the behavioural rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_cnt   = '0;
            m_drain = 0;
        end else begin
            if (preload)
                m_cnt = 64'hFFFF_FFFD;
            else if (exp_en() && m_cnt < 64'hFFFF_FFFF)
                m_cnt = m_cnt + 64'd1;
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (bus.cmd_stop)      m_state = 1;
                    else if (bus.cmd_run)  m_state = 2;
                    else if (bus.cmd_step) m_state = 3;
                end
                2: begin
                    if (bus.halt_instr) begin
                        m_state = 4;
                        m_drain = DC;
                    end else if (bus.cmd_stop) m_state = 1;
                end
                3: begin
                    if (bus.halt_instr) begin
                        m_state = 4;
                        m_drain = DC;
                    end else if (!bus.stall) m_state = 1;
                end
                4: begin
                    m_drain = m_drain - 1;
                    if (m_drain == 0) m_state = 5;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_pc_enable", 64'(bus.pc_enable), 64'(exp_en()));
            check("m_pc_next", 64'(bus.pc_next), exp_next());
            check("m_flush", 64'(bus.flush),
                  64'(exp_en() && (bus.branch_taken || bus.jump)));
            check("m_state", 64'(bus.state_out), 64'(m_state));
            check("m_halted", 64'(bus.halted), 64'(m_state == 5));
            if (cnt_chk)
                check("m_fetch_count", 64'(bus.fetch_count), m_cnt);
        end
    end

    task automatic clr();
        bus.cmd_run       = 1'b0;
        bus.cmd_step      = 1'b0;
        bus.cmd_stop      = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.halt_instr    = 1'b0;
        pc_load           = 1'b0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        clr();
    endtask

    int pulses;

    initial begin
        clr();
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        // 1: reset then boot
        @(negedge clk);
        check("reset_en", 64'(bus.pc_enable), 64'd0);
        check("reset_state", 64'(bus.state_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("boot_en", 64'(bus.pc_enable), 64'd1);
        check("boot_next", 64'(bus.pc_next), 64'd0);
        go();
        @(negedge clk);
        check("idle_state", 64'(bus.state_out), 64'd1);
        check("boot_count", 64'(bus.fetch_count), 64'd1);
        check("idle_en", 64'(bus.pc_enable), 64'd0);
        // 2: free run and stall
        go();
        bus.cmd_run = 1'b1;
        @(negedge clk);
        go();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("run_next", 64'(bus.pc_next), 64'(4 * i));
            go();
        end
        for (int i = 0; i < 2; i++) begin
            bus.stall = 1'b1;
            @(negedge clk);
            check("stall_en", 64'(bus.pc_enable), 64'd0);
            check("stall_count", 64'(bus.fetch_count), 64'd4);
            go();
        end
        // 3: branch beats jump, stall blocks flush
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h80;
        @(negedge clk);
        check("br_next", 64'(bus.pc_next), 64'h40);
        check("br_flush", 64'(bus.flush), 64'd1);
        go();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h80;
        bus.stall         = 1'b1;
        @(negedge clk);
        check("br_stall_flush", 64'(bus.flush), 64'd0);
        check("br_stall_en", 64'(bus.pc_enable), 64'd0);
        go();
        // 4: stop, then single step under stall
        bus.cmd_stop = 1'b1;
        @(negedge clk);
        check("stop_next", 64'(bus.pc_next), 64'h44);
        go();
        bus.cmd_step = 1'b1;
        bus.stall    = 1'b1;
        @(negedge clk);
        check("step_issue_state", 64'(bus.state_out), 64'd1);
        go();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus.stall = (i < 3);
            @(negedge clk);
            check("step_state", 64'(bus.state_out), 64'd3);
            pulses += int'(bus.pc_enable);
            go();
        end
        check("step_pulses", 64'(pulses), 64'd1);
        @(negedge clk);
        check("step_done", 64'(bus.state_out), 64'd1);
        go();
        bus.cmd_step = 1'b1;
        bus.cmd_stop = 1'b1;
        @(negedge clk);
        go();
        @(negedge clk);
        check("step_stop", 64'(bus.state_out), 64'd1);
        // 5: halt, drain, halted, reset
        go();
        bus.cmd_run = 1'b1;
        @(negedge clk);
        go();
        bus.halt_instr = 1'b1;
        @(negedge clk);
        check("halt_en", 64'(bus.pc_enable), 64'd0);
        go();
        for (int i = 0; i < DC; i++) begin
            @(negedge clk);
            check("drain_state", 64'(bus.state_out), 64'd4);
            go();
        end
        @(negedge clk);
        check("halted_state", 64'(bus.state_out), 64'd5);
        check("halted_flag", 64'(bus.halted), 64'd1);
        go();
        bus.cmd_run = 1'b1;
        @(negedge clk);
        go();
        @(negedge clk);
        check("halted_sticky", 64'(bus.state_out), 64'd5);
        go();
        reset = 1'b1;
        @(negedge clk);
        check("rst2_state", 64'(bus.state_out), 64'd0);
        check("rst2_count", 64'(bus.fetch_count), 64'd0);
        check("rst2_en", 64'(bus.pc_enable), 64'd0);
        go();
        reset = 1'b0;
        @(negedge clk);
        check("boot2_en", 64'(bus.pc_enable), 64'd1);
        go();
        // 6: wrap and counter saturation
        bus.cmd_run = 1'b1;
        @(negedge clk);
        go();
        pc_load     = 1'b1;
        pc_load_val = 32'hFFFF_FFFC;
        @(negedge clk);
        go();
        bus.cmd_stop = 1'b1;
        @(negedge clk);
        check("wrap_next", 64'(bus.pc_next), 64'd0);
        go();
        force dut.fetch_cnt = 32'hFFFF_FFFD;
        cnt_chk = 1'b0;
        preload = 1'b1;
        @(negedge clk);
        go();
        release dut.fetch_cnt;
        preload = 1'b0;
        cnt_chk = 1'b1;
        @(negedge clk);
        check("preload_count", 64'(bus.fetch_count), 64'hFFFF_FFFD);
        go();
        bus.cmd_run = 1'b1;
        @(negedge clk);
        go();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            go();
        end
        @(negedge clk);
        check("sat_count", 64'(bus.fetch_count), 64'hFFFF_FFFF);
        check("sat_en", 64'(bus.pc_enable), 64'd1);
        go();
        @(negedge clk);
        check("sat_hold", 64'(bus.fetch_count), 64'hFFFF_FFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that sequences the program counter register of the pipelined CPU.
- Drives the PC register's enable and next-address inputs; reads the PC register's current output back.
- Selects the next fetch address: sequential, branch or jump.
- Runs the run / single-step / stop / halt control FSM used by the debug unit, and counts fetch cycles.

Parameters:
ADDR_WIDTH, 32, width of all address ports
RESET_ADDR, 32'h0000_0000, address loaded into the PC in the BOOT state
DRAIN_CYCLES, 4, cycles to let the pipeline empty after a halt instruction (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_run  input  1  debug pulse: free-run
cmd_step  input  1  debug pulse: fetch one instruction
cmd_stop  input  1  debug pulse: stop free-run
pc_current  input  ADDR_WIDTH  current PC register output
stall  input  1  hazard unit load-use stall
branch_taken  input  1  branch resolved taken (ID stage)
branch_target  input  ADDR_WIDTH  branch destination
jump  input  1  jump decoded (ID stage)
jump_target  input  ADDR_WIDTH  jump destination
halt_instr  input  1  halt opcode decoded in ID
pc_enable  output  1  write enable for the PC register
pc_next  output  ADDR_WIDTH  address the PC register loads
flush  output  1  squash the IF/ID register
state_out  output  3  current FSM state encoding
halted  output  1  core permanently halted
fetch_count  output  32  number of PC updates since reset

Behaviour:
- States and encodings: BOOT=0, IDLE=1, RUN=2, STEP=3, DRAIN=4, HALTED=5. State is registered; reset forces BOOT asynchronously.
- Reset values: state BOOT, fetch_count 0, drain counter 0, halted 0.
- pc_enable, pc_next and flush are combinational from the state and inputs.
- BOOT: pc_next=RESET_ADDR, pc_enable=1 for exactly one cycle; stall is ignored. Next state IDLE. This is the only way the PC is initialised.
- Address mux outside BOOT, in priority order:
  - branch_taken -> branch_target
  - else jump -> jump_target
  - else pc_current + 4, with wrap-around modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 0).
- Fetch condition: pc_enable = (state RUN or STEP) and !stall.
- flush = pc_enable and (branch_taken or jump). flush is 0 while stalled.
- Command priority when pulses coincide: stop > run > step.
- IDLE:
  - cmd_run -> RUN.
  - cmd_step -> STEP.
  - cmd_stop -> stay in IDLE.
- RUN:
  - halt_instr -> DRAIN, with pc_enable forced 0 in that same cycle.
  - else cmd_stop -> IDLE; the PC still updates in that cycle if it is not stalled.
  - cmd_step and cmd_run are ignored.
- STEP:
  - Held while stall=1.
  - Returns to IDLE after the first cycle with pc_enable=1 (exactly one PC update).
  - halt_instr -> DRAIN, with pc_enable=0.
- DRAIN:
  - pc_enable=0.
  - The drain counter is loaded with DRAIN_CYCLES-1 on entry and decrements each cycle.
  - Moves to HALTED when the counter reaches 0, so DRAIN lasts exactly DRAIN_CYCLES cycles. All commands are ignored.
- HALTED: pc_enable=0, halted=1. This state is terminal; only reset leaves it.
- fetch_count: increments on every cycle with pc_enable=1, including BOOT, and saturates at 32'hFFFF_FFFF.
- Reset asserted mid-operation: returns to BOOT immediately and clears fetch_count. pc_enable is 1 only after reset deasserts.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encoding constants BOOT…HALTED;
  - INSTR_BYTES=4;
  - the ADDR_WIDTH default.
- Sub-module pc_next_mux (purely combinational address select plus the +4 adder), instantiated once. The FSM, drain counter and fetch counter stay in pc_sequencer.

Test Plan:
1. Reset pulse, then release -> one cycle with pc_enable=1 and pc_next=0; state_out 0→1; fetch_count=1; then pc_enable stays 0 in IDLE.
2. cmd_run, no hazards, pc_current tracking -> pc_next 4, 8, 12 on consecutive cycles. stall=1 for 2 cycles -> pc_enable=0 for those 2 cycles and fetch_count frozen.
3. In RUN, branch_taken=1 with branch_target=32'h40 and jump=1 with jump_target=32'h80 in the same cycle -> pc_next=32'h40 and flush=1. Repeat with stall=1 -> flush=0 and pc_enable=0.
4. In IDLE: cmd_step with stall=1 for 3 cycles -> state STEP for 4 cycles and exactly one pc_enable pulse, then IDLE. Same-cycle cmd_step and cmd_stop -> remain IDLE.
5. In RUN, halt_instr=1 -> pc_enable=0 that cycle; state DRAIN for 4 cycles, then HALTED with halted=1. cmd_run in HALTED has no effect; reset returns to BOOT.
6. pc_current=32'hFFFF_FFFC in RUN -> pc_next=0. Preload fetch_count near max (force) -> it saturates at 32'hFFFF_FFFF.
